// File: rtl/sys_defs.sv
// Shared system definitions: bus command encoding, tag count and memory timing defaults.
package sys_defs;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned DATA_W              = 64;
  localparam int unsigned NUM_MEM_TAGS        = 15;
  localparam int unsigned TAG_W               = 4;
  localparam int unsigned MEM_LATENCY_DEFAULT = 10;

  // Command value 3 is not enumerated and decodes as no request.
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_e;

  // One slot of the load-return pipeline; invalid slots carry all-zero tag and data.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } mem_ret_t;

endpackage

// File: rtl/mem_responder_if.sv
// Processor-to-memory bus plus the preload port used to seed storage.
interface mem_responder_if;
  import sys_defs::*;

  logic [1:0]        proc2mem_command;
  logic [XLEN-1:0]   proc2mem_addr;
  logic [DATA_W-1:0] proc2mem_data;
  logic              dbg_wr_en;
  logic [XLEN-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [TAG_W-1:0]  mem2proc_response;
  logic [DATA_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_tag;

  // Requester side.
  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output dbg_wr_en, dbg_addr, dbg_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  // Memory side.
  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  dbg_wr_en, dbg_addr, dbg_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );

endinterface

// File: rtl/mem_tag_alloc.sv
// Tag busy vector with a lowest-free priority encoder; tags are numbered 1..NUM_MEM_TAGS.
module mem_tag_alloc
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_tag,
  output logic [TAG_W-1:0] lowest_free_c,
  output logic             any_free_c
);

  // Bit i tracks tag i+1.
  logic [NUM_MEM_TAGS-1:0] busy;
  logic [NUM_MEM_TAGS-1:0] busy_nxt;

  // Lowest idle tag from registered state only; a tag freed this cycle is not yet visible.
  always_comb begin
    lowest_free_c = '0;
    any_free_c    = 1'b0;
    for (int i = int'(NUM_MEM_TAGS) - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        lowest_free_c = TAG_W'(i + 1);
        any_free_c    = 1'b1;
      end
    end
  end

  // Clear the returning tag and set the newly allocated one; they can never coincide.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < int'(NUM_MEM_TAGS); i++) begin
      if (free_en && (free_tag == TAG_W'(i + 1))) begin
        busy_nxt[i] = 1'b0;
      end
      if (alloc_en && (lowest_free_c == TAG_W'(i + 1))) begin
        busy_nxt[i] = 1'b1;
      end
    end
  end

  // Busy vector register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Tagged fixed-latency memory model: accepts one load/store per cycle, returns load data
// MEM_LATENCY cycles after acceptance through a shift pipeline, in acceptance order.
module mem_responder
  import sys_defs::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT,
  parameter int unsigned MEM_WORDS   = 8192
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned WORD_W = XLEN - 3;
  localparam int unsigned LAST   = MEM_LATENCY - 1;

  logic [WORD_W-1:0] req_word;
  logic [WORD_W-1:0] dbg_word;
  logic              req_in_range;
  logic              dbg_in_range;
  logic              is_load;
  logic              is_store;
  logic              load_acc;
  logic              store_acc;
  logic              dbg_acc;
  logic [TAG_W-1:0]  alloc_tag;
  logic              tag_avail;
  mem_ret_t          ret_new;
  mem_ret_t          ret_out;
  mem_ret_t          pipe [MEM_LATENCY];
  logic [DATA_W-1:0] mem  [MEM_WORDS];
  logic              unused_addr_bits;

  // Byte-offset bits carry no information for 64-bit words.
  assign unused_addr_bits = ^{bus.proc2mem_addr[2:0], bus.dbg_addr[2:0]};

  // Request decode and acceptance; a store also needs a free tag since its response is one.
  always_comb begin
    req_word     = bus.proc2mem_addr[XLEN-1:3];
    dbg_word     = bus.dbg_addr[XLEN-1:3];
    req_in_range = (req_word < WORD_W'(MEM_WORDS));
    dbg_in_range = (dbg_word < WORD_W'(MEM_WORDS));
    is_load      = (bus.proc2mem_command == BUS_LOAD);
    is_store     = (bus.proc2mem_command == BUS_STORE);
    load_acc     = !reset && is_load  && req_in_range && tag_avail;
    store_acc    = !reset && is_store && req_in_range && tag_avail;
    dbg_acc      = bus.dbg_wr_en && dbg_in_range;
  end

  // Same-cycle response straight from registered tag state and the current command.
  assign bus.mem2proc_response = (load_acc || store_acc) ? alloc_tag : '0;

  mem_tag_alloc u_tag_alloc (
    .clock         (clock),
    .reset         (reset),
    .alloc_en      (load_acc),
    .free_en       (ret_out.valid),
    .free_tag      (ret_out.tag),
    .lowest_free_c (alloc_tag),
    .any_free_c    (tag_avail)
  );

  // Entry entering the pipeline: snapshot of the addressed word for an accepted load.
  always_comb begin
    ret_new = '0;
    if (load_acc) begin
      ret_new.valid = 1'b1;
      ret_new.tag   = alloc_tag;
      ret_new.data  = mem[req_word[IDX_W-1:0]];
    end
  end

  // Return pipeline; reset drops everything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= ret_new;
      for (int i = 1; i < int'(MEM_LATENCY); i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Storage writes; the preload port is applied last so it wins a same-word collision.
  always_ff @(posedge clock) begin
    if (store_acc) begin
      mem[req_word[IDX_W-1:0]] <= bus.proc2mem_data;
    end
    if (dbg_acc) begin
      mem[dbg_word[IDX_W-1:0]] <= bus.dbg_data;
    end
  end

  // Oldest slot drives the return bus; invalid slots are all-zero.
  assign ret_out           = pipe[LAST];
  assign bus.mem2proc_tag  = ret_out.tag;
  assign bus.mem2proc_data = ret_out.data;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency-4 instance for most scenarios, latency-20 for tag exhaustion.
module tb_mem_responder;
  import sys_defs::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  mem_responder_if m ();
  mem_responder_if m2 ();

  mem_responder #(.MEM_LATENCY(4), .MEM_WORDS(8192)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (m)
  );

  mem_responder #(.MEM_LATENCY(20), .MEM_WORDS(64)) u_dut_long (
    .clock (clock),
    .reset (reset),
    .bus   (m2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle: sample returns at negedge, drive the command, then sample the combinational response.
  task automatic step(input int sel, input logic [1:0] cmd, input logic [31:0] addr,
                      input logic [63:0] data, output logic [3:0] resp,
                      output logic [3:0] rtag, output logic [63:0] rdata);
    @(negedge clock);
    if (sel == 0) begin
      rtag  = m.mem2proc_tag;
      rdata = m.mem2proc_data;
      m.proc2mem_command = cmd;
      m.proc2mem_addr    = addr;
      m.proc2mem_data    = data;
      #1;
      resp = m.mem2proc_response;
    end else begin
      rtag  = m2.mem2proc_tag;
      rdata = m2.mem2proc_data;
      m2.proc2mem_command = cmd;
      m2.proc2mem_addr    = addr;
      m2.proc2mem_data    = data;
      #1;
      resp = m2.mem2proc_response;
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [63:0] d);
    @(negedge clock);
    m.dbg_wr_en = 1'b1;
    m.dbg_addr  = a;
    m.dbg_data  = d;
    @(posedge clock);
    #1;
    m.dbg_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    m.proc2mem_command  = BUS_LOAD;
    m.proc2mem_addr     = 32'h0;
    m2.proc2mem_command = BUS_LOAD;
    m2.proc2mem_addr    = 32'h0;
    @(negedge clock);
    #1;
    checks++; if (m.mem2proc_response !== 4'd0) begin failures++; $display("FAIL reset_resp: got %0d want 0", m.mem2proc_response); end
    checks++; if (m.mem2proc_tag !== 4'd0) begin failures++; $display("FAIL reset_tag: got %0d want 0", m.mem2proc_tag); end
    checks++; if (m.mem2proc_data !== 64'd0) begin failures++; $display("FAIL reset_data: got %h want 0", m.mem2proc_data); end
    checks++; if (m2.mem2proc_response !== 4'd0) begin failures++; $display("FAIL reset_resp_long: got %0d want 0", m2.mem2proc_response); end
    m.proc2mem_command  = BUS_NONE;
    m2.proc2mem_command = BUS_NONE;
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    logic [3:0] resp, rtag; logic [63:0] rdata;
    for (int c = 0; c < 6; c++) begin
      step(0, (c == 0) ? BUS_LOAD : BUS_NONE, 32'h40, 64'd0, resp, rtag, rdata);
      checks++; if (resp !== ((c == 0) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL single_resp c%0d: got %0d want %0d", c, resp, (c == 0) ? 1 : 0); end
      checks++; if (rtag !== ((c == 4) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL single_tag c%0d: got %0d want %0d", c, rtag, (c == 4) ? 1 : 0); end
      checks++; if (rdata !== ((c == 4) ? 64'hDEADBEEF_00000001 : 64'd0)) begin failures++; $display("FAIL single_data c%0d: got %h", c, rdata); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] resp, rtag; logic [63:0] rdata, exp_d;
    logic [3:0] exp_r [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] exp_t [11] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd0};
    for (int c = 0; c < 11; c++) begin
      step(0, (c < 6) ? BUS_LOAD : BUS_NONE, 32'(c * 8), 64'd0, resp, rtag, rdata);
      exp_d = (c >= 4 && c <= 9) ? 64'(32'h100 + 32'(c - 4)) : 64'd0;
      checks++; if (resp !== exp_r[c]) begin failures++; $display("FAIL b2b_resp c%0d: got %0d want %0d", c, resp, exp_r[c]); end
      checks++; if (rtag !== exp_t[c]) begin failures++; $display("FAIL b2b_tag c%0d: got %0d want %0d", c, rtag, exp_t[c]); end
      checks++; if (rdata !== exp_d) begin failures++; $display("FAIL b2b_data c%0d: got %h want %h", c, rdata, exp_d); end
    end
  endtask

  task automatic test_store_load();
    logic [3:0] resp, rtag; logic [63:0] rdata;
    logic [1:0] cmd;
    for (int c = 0; c < 7; c++) begin
      cmd = (c == 0) ? 2'(BUS_STORE) : (c == 1) ? 2'(BUS_LOAD) : 2'(BUS_NONE);
      step(0, cmd, 32'h80, 64'h1234, resp, rtag, rdata);
      checks++; if (resp !== ((c < 2) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL stld_resp c%0d: got %0d want %0d", c, resp, (c < 2) ? 1 : 0); end
      checks++; if (rtag !== ((c == 5) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL stld_tag c%0d: got %0d want %0d", c, rtag, (c == 5) ? 1 : 0); end
      checks++; if (rdata !== ((c == 5) ? 64'h1234 : 64'd0)) begin failures++; $display("FAIL stld_data c%0d: got %h", c, rdata); end
    end
  endtask

  task automatic test_dbg_wins();
    logic [3:0] resp, rtag; logic [63:0] rdata;
    m.dbg_wr_en = 1'b1;
    m.dbg_addr  = 32'h200;
    m.dbg_data  = 64'hAAAA;
    step(0, BUS_STORE, 32'h200, 64'hBBBB, resp, rtag, rdata);
    checks++; if (resp !== 4'd1) begin failures++; $display("FAIL dbgwin_store_resp: got %0d want 1", resp); end
    step(0, BUS_LOAD, 32'h200, 64'd0, resp, rtag, rdata);
    m.dbg_wr_en = 1'b0;
    checks++; if (resp !== 4'd1) begin failures++; $display("FAIL dbgwin_load_resp: got %0d want 1", resp); end
    for (int c = 2; c < 7; c++) begin
      step(0, BUS_NONE, 32'h0, 64'd0, resp, rtag, rdata);
      checks++; if (rtag !== ((c == 5) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL dbgwin_tag c%0d: got %0d want %0d", c, rtag, (c == 5) ? 1 : 0); end
      checks++; if (rdata !== ((c == 5) ? 64'hAAAA : 64'd0)) begin failures++; $display("FAIL dbgwin_data c%0d: got %h", c, rdata); end
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] resp, rtag; logic [63:0] rdata;
    logic [1:0]  cmd_v  [5] = '{2'(BUS_LOAD), 2'(BUS_STORE), 2'(BUS_LOAD), 2'(BUS_LOAD), 2'(BUS_LOAD)};
    logic [31:0] addr_v [5] = '{32'h10000, 32'h10000, 32'h0, 32'hFFF8, 32'h43};
    logic [3:0]  exp_r  [5] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
    logic [3:0]  exp_t  [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic [63:0] exp_d  [10] = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h100, 64'h77,
                                 64'hDEADBEEF_00000001, 64'd0};
    for (int c = 0; c < 10; c++) begin
      if (c < 5) step(0, cmd_v[c], addr_v[c], 64'hBAD, resp, rtag, rdata);
      else       step(0, BUS_NONE, 32'h0, 64'd0, resp, rtag, rdata);
      if (c < 5) begin
        checks++; if (resp !== exp_r[c]) begin failures++; $display("FAIL oor_resp c%0d: got %0d want %0d", c, resp, exp_r[c]); end
      end
      checks++; if (rtag !== exp_t[c]) begin failures++; $display("FAIL oor_tag c%0d: got %0d want %0d", c, rtag, exp_t[c]); end
      checks++; if (rdata !== exp_d[c]) begin failures++; $display("FAIL oor_data c%0d: got %h want %h", c, rdata, exp_d[c]); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] resp, rtag; logic [63:0] rdata;
    for (int c = 0; c < 5; c++) begin
      step(0, (c == 0) ? BUS_LOAD : BUS_NONE, 32'h40, 64'd0, resp, rtag, rdata);
    end
    checks++; if (rtag !== 4'd1) begin failures++; $display("FAIL arst_pre_tag: got %0d want 1", rtag); end
    m.proc2mem_command = BUS_LOAD;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (m.mem2proc_tag !== 4'd0) begin failures++; $display("FAIL arst_tag: got %0d want 0", m.mem2proc_tag); end
    checks++; if (m.mem2proc_data !== 64'd0) begin failures++; $display("FAIL arst_data: got %h want 0", m.mem2proc_data); end
    checks++; if (m.mem2proc_response !== 4'd0) begin failures++; $display("FAIL arst_resp: got %0d want 0", m.mem2proc_response); end
    m.proc2mem_command = BUS_NONE;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    logic [3:0] resp, rtag; logic [63:0] rdata;
    step(0, BUS_LOAD, 32'h0, 64'd0, resp, rtag, rdata);
    checks++; if (resp !== 4'd1) begin failures++; $display("FAIL rif_resp0: got %0d want 1", resp); end
    step(0, BUS_LOAD, 32'h8, 64'd0, resp, rtag, rdata);
    checks++; if (resp !== 4'd2) begin failures++; $display("FAIL rif_resp1: got %0d want 2", resp); end
    @(negedge clock);
    m.proc2mem_command = BUS_NONE;
    reset = 1'b1;
    #1;
    checks++; if (m.mem2proc_tag !== 4'd0) begin failures++; $display("FAIL rif_tag c2: got %0d want 0", m.mem2proc_tag); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 3; c < 17; c++) begin
      step(0, (c == 11) ? BUS_LOAD : BUS_NONE, 32'h0, 64'd0, resp, rtag, rdata);
      if (c == 11) begin
        checks++; if (resp !== 4'd1) begin failures++; $display("FAIL rif_first_resp: got %0d want 1", resp); end
      end
      checks++; if (rtag !== ((c == 15) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL rif_tag c%0d: got %0d want %0d", c, rtag, (c == 15) ? 1 : 0); end
      checks++; if (rdata !== ((c == 15) ? 64'h100 : 64'd0)) begin failures++; $display("FAIL rif_data c%0d: got %h", c, rdata); end
    end
  endtask

  task automatic test_tag_exhaust();
    logic [3:0] resp, rtag, exp_r, exp_t; logic [63:0] rdata;
    for (int c = 0; c < 43; c++) begin
      step(1, (c <= 15 || c == 20 || c == 21) ? BUS_LOAD : BUS_NONE, 32'h0, 64'd0, resp, rtag, rdata);
      exp_r = (c < 15) ? 4'(c + 1) : (c == 21) ? 4'd1 : 4'd0;
      exp_t = (c >= 20 && c <= 34) ? 4'(c - 19) : (c == 41) ? 4'd1 : 4'd0;
      checks++; if (resp !== exp_r) begin failures++; $display("FAIL exhaust_resp c%0d: got %0d want %0d", c, resp, exp_r); end
      checks++; if (rtag !== exp_t) begin failures++; $display("FAIL exhaust_tag c%0d: got %0d want %0d", c, rtag, exp_t); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    m.proc2mem_command  = BUS_NONE;
    m.proc2mem_addr     = '0;
    m.proc2mem_data     = '0;
    m.dbg_wr_en         = 1'b0;
    m.dbg_addr          = '0;
    m.dbg_data          = '0;
    m2.proc2mem_command = BUS_NONE;
    m2.proc2mem_addr    = '0;
    m2.proc2mem_data    = '0;
    m2.dbg_wr_en        = 1'b0;
    m2.dbg_addr         = '0;
    m2.dbg_data         = '0;

    test_reset();
    preload(32'h40, 64'hDEADBEEF_00000001);
    for (int i = 0; i < 6; i++) preload(32'(i * 8), 64'(32'h100 + 32'(i)));
    preload(32'hFFF8, 64'h77);

    test_single_load();
    test_back_to_back();
    test_store_load();
    test_dbg_wins();
    test_out_of_range();
    test_async_reset();
    test_reset_in_flight();
    test_tag_exhaust();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
